zx_tape_fastload: RTL

- Parametrised fast tape loader for the ZX80/ZX81 core.
- Traps the ROM LOAD entry on an M1 fetch and overlays a 7-byte loop patch onto the CPU data path.
- While the CPU spins in the patch, copies the downloaded tape image from the tape buffer into system RAM, then releases the CPU back to ROM.
- Replaces the hard-wired loader logic in the core top level with a model- and format-generic block of configurable buffer depth.

---
 rtl/zx_tape_pkg.sv | 42 ++++
 rtl/zx_tape_patch_rom.sv | 41 ++++
 rtl/zx_tape_fastload.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/zx_tape_pkg.sv
// ---------------------------------------------------------------------------
// zx_tape_pkg
// Shared definitions for the ZX80/ZX81 fast tape loader:
//   - loader state encoding
//   - ROM LOAD trap entry addresses and trap window end addresses
//   - the 7-byte loop patch template and its variable bytes
//   - helpers that select the trap addresses for the current model
// ---------------------------------------------------------------------------
package zx_tape_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COPY_RD = 2'd1,
        COPY_WR = 2'd2,
        FINISH  = 2'd3
    } zx_tape_state_t;

    localparam logic [15:0] ZX81_ENTRY = 16'h0347;
    localparam logic [15:0] ZX81_WEND  = 16'h03C2;
    localparam logic [15:0] ZX80_ENTRY = 16'h0207;
    localparam logic [15:0] ZX80_WEND  = 16'h024C;

    // Patch loop: xor a / P1 / jr nc,-3 / jp LO02.
    // Bytes 1 (P1) and 5 (LO) are placeholders filled in at lookup time.
    localparam logic [6:0][7:0] PATCH_TEMPLATE = {
        8'h02, 8'h00, 8'hC3, 8'hFD, 8'h30, 8'h00, 8'hAF
    };

    localparam logic [7:0] P1_NOP  = 8'h00;
    localparam logic [7:0] P1_SCF  = 8'h37;
    localparam logic [7:0] LO_ZX81 = 8'h07;
    localparam logic [7:0] LO_ZX80 = 8'h03;

    function automatic logic [15:0] trap_entry(input logic zx81);
        return zx81 ? ZX81_ENTRY : ZX80_ENTRY;
    endfunction

    function automatic logic [15:0] trap_wend(input logic zx81);
        return zx81 ? ZX81_WEND : ZX80_WEND;
    endfunction

endpackage

// File: rtl/zx_tape_patch_rom.sv
// ---------------------------------------------------------------------------
// zx_tape_patch_rom
// Combinational lookup of the loop-patch byte for the current CPU address.
// Ports:
//   i_cpu_addr  CPU address bus
//   i_zx81      model select (1 = ZX81, 0 = ZX80)
//   i_finished  copy finished: P1 becomes scf instead of nop
//   o_data      patch byte, 0 outside the 7-byte patch
// ---------------------------------------------------------------------------
module zx_tape_patch_rom
    import zx_tape_pkg::*;
(
    input  logic [15:0] i_cpu_addr,
    input  logic        i_zx81,
    input  logic        i_finished,
    output logic [7:0]  o_data
);

    logic [15:0] w_index;

    // Select the patch byte by offset from the trap entry address.
    always_comb begin
        w_index = i_cpu_addr - trap_entry(i_zx81);
        o_data  = 8'h00;
        if (w_index <= 16'd6) begin
            case (w_index[2:0])
                3'd0:    o_data = PATCH_TEMPLATE[0];
                3'd1:    o_data = i_finished ? P1_SCF : P1_NOP;
                3'd2:    o_data = PATCH_TEMPLATE[2];
                3'd3:    o_data = PATCH_TEMPLATE[3];
                3'd4:    o_data = PATCH_TEMPLATE[4];
                3'd5:    o_data = i_zx81 ? LO_ZX81 : LO_ZX80;
                3'd6:    o_data = PATCH_TEMPLATE[6];
                default: o_data = 8'h00;
            endcase
        end else begin
            o_data = 8'h00;
        end
    end

endmodule

// File: rtl/zx_tape_fastload.sv
// ---------------------------------------------------------------------------
// zx_tape_fastload
// Fast tape loader: traps the ROM LOAD entry on an M1 fetch, overlays a
// 7-byte spin loop on the CPU data path and, while the CPU spins, copies the
// tape image from the tape buffer into system RAM (one byte per ce_cpu_p).
// Optional build macro ZX_TAPE_PLEN_EN: for .p images, stop the copy at the
// E_LINE address captured from image bytes 11/12.
// Ports:
//   clk_sys, reset         clock, synchronous active-high reset
//   ce_cpu_p               CPU clock enable, one copy slot per strobe
//   zx81, fmt_p            model and image format select
//   tape_ready, tape_len   image present, image length in bytes
//   cpu_addr, cpu_nm1      CPU address bus and M1_n
//   buf_addr, buf_data     tape buffer read port (1-cycle read latency)
//   ram_addr/dout/we       RAM write port
//   active, patch_data     patch overlay enable and patch byte
//   done                   1-cycle pulse when the CPU is released
// ---------------------------------------------------------------------------
module zx_tape_fastload
    import zx_tape_pkg::*;
#(
    parameter int          TAPE_AW  = 14,
    parameter logic [15:0] RAM_BASE = 16'h4000,
    parameter logic [15:0] P_OFFSET = 16'd9
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ce_cpu_p,
    input  logic               zx81,
    input  logic               fmt_p,
    input  logic               tape_ready,
    input  logic [TAPE_AW-1:0] tape_len,
    input  logic [15:0]        cpu_addr,
    input  logic               cpu_nm1,
    output logic [TAPE_AW-1:0] buf_addr,
    input  logic [7:0]         buf_data,
    output logic [15:0]        ram_addr,
    output logic [7:0]         ram_dout,
    output logic               ram_we,
    output logic               active,
    output logic [7:0]         patch_data,
    output logic               done
);

    zx_tape_state_t     r_state, w_state_nxt;
    logic [TAPE_AW-1:0] r_cnt, w_cnt_nxt;
    logic               r_finished, w_finished_nxt;
    logic               r_active, w_active_nxt;
    logic               r_done, w_done_nxt;
    logic               r_ram_we, w_ram_we_nxt;
    logic [15:0]        r_ram_addr, w_ram_addr_nxt;
    logic [7:0]         r_ram_dout, w_ram_dout_nxt;
    logic               r_nm1_prev;

    logic               w_m1_edge;
    logic               w_restart;
    logic               w_exit;
    logic [15:0]        w_dest;
    logic               w_stop;
    logic [7:0]         w_patch;

`ifdef ZX_TAPE_PLEN_EN
    logic [15:0]        r_eline, w_eline_nxt;
`endif

    assign w_m1_edge = r_nm1_prev && !cpu_nm1;
    assign w_restart = w_m1_edge && (cpu_addr == trap_entry(zx81));
    assign w_exit    = w_m1_edge && ((cpu_addr < trap_entry(zx81)) ||
                                     (cpu_addr > trap_wend(zx81)));
    // Destination wraps in 16 bits by construction.
    assign w_dest    = RAM_BASE + 16'(r_cnt) + (fmt_p ? P_OFFSET : 16'h0000);

`ifdef ZX_TAPE_PLEN_EN
    assign w_stop = (r_cnt == tape_len) ||
                    (fmt_p && (r_cnt >= TAPE_AW'(12)) && (w_dest == r_eline));
`else
    assign w_stop = (r_cnt == tape_len);
`endif

    // Next-state and next-output logic of the loader FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_finished_nxt = r_finished;
        w_active_nxt   = r_active;
        w_done_nxt     = 1'b0;
        w_ram_we_nxt   = 1'b0;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_dout_nxt = r_ram_dout;
`ifdef ZX_TAPE_PLEN_EN
        w_eline_nxt    = r_eline;
`endif
        case (r_state)
            IDLE: begin
                if (w_restart && tape_ready) begin
                    w_state_nxt    = COPY_RD;
                    w_active_nxt   = 1'b1;
                    w_cnt_nxt      = '0;
                    w_finished_nxt = 1'b0;
`ifdef ZX_TAPE_PLEN_EN
                    w_eline_nxt    = 16'h0000;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            COPY_RD, FINISH: begin
                if (w_exit) begin
                    w_state_nxt  = IDLE;
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end else if (w_restart) begin
                    w_state_nxt    = COPY_RD;
                    w_cnt_nxt      = '0;
                    w_finished_nxt = 1'b0;
`ifdef ZX_TAPE_PLEN_EN
                    w_eline_nxt    = 16'h0000;
`endif
                end else if ((r_state == COPY_RD) && ce_cpu_p) begin
                    if (w_stop) begin
                        w_state_nxt    = FINISH;
                        w_finished_nxt = 1'b1;
                    end else begin
                        w_state_nxt = COPY_WR;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            COPY_WR: begin
                // The write completes even when the CPU leaves or restarts now.
                w_ram_we_nxt   = 1'b1;
                w_ram_addr_nxt = w_dest;
                w_ram_dout_nxt = buf_data;
`ifdef ZX_TAPE_PLEN_EN
                if (fmt_p && (r_cnt == TAPE_AW'(11))) begin
                    w_eline_nxt[7:0] = buf_data;
                end else if (fmt_p && (r_cnt == TAPE_AW'(12))) begin
                    w_eline_nxt[15:8] = buf_data;
                end else begin
                    w_eline_nxt = r_eline;
                end
`endif
                if (w_exit) begin
                    w_state_nxt  = IDLE;
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end else if (w_restart) begin
                    w_state_nxt    = COPY_RD;
                    w_cnt_nxt      = '0;
                    w_finished_nxt = 1'b0;
`ifdef ZX_TAPE_PLEN_EN
                    w_eline_nxt    = 16'h0000;
`endif
                end else begin
                    w_state_nxt = COPY_RD;
                    w_cnt_nxt   = r_cnt + TAPE_AW'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any copy immediately.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_finished <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= 16'h0000;
            r_ram_dout <= 8'h00;
            r_nm1_prev <= 1'b1;
`ifdef ZX_TAPE_PLEN_EN
            r_eline    <= 16'h0000;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_finished <= w_finished_nxt;
            r_active   <= w_active_nxt;
            r_done     <= w_done_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_dout <= w_ram_dout_nxt;
            r_nm1_prev <= cpu_nm1;
`ifdef ZX_TAPE_PLEN_EN
            r_eline    <= w_eline_nxt;
`endif
        end
    end

    zx_tape_patch_rom u_patch_rom (
        .i_cpu_addr (cpu_addr),
        .i_zx81     (zx81),
        .i_finished (r_finished),
        .o_data     (w_patch)
    );

    // The counter doubles as the buffer read address, so the buffer has
    // already sampled byte cnt when the read slot fires and its data is
    // valid in the following write cycle.
    assign buf_addr   = r_cnt;
    assign ram_addr   = r_ram_addr;
    assign ram_dout   = r_ram_dout;
    assign ram_we     = r_ram_we;
    assign active     = r_active;
    assign done       = r_done;
    assign patch_data = r_active ? w_patch : 8'h00;

endmodule
